rf_write_arbiter: RTL and testbench

- Shares the single register-file write port between the pipeline writeback stage and the multicycle (mult/div) result path.
- Buffers multicycle results in a small FIFO and keeps a pending-destination scoreboard so decode can stall on RAW hazards.
- Sits between WB/multicycle unit and the register file write port (RegWrite/W/WData).

---
 rtl/rf_write_arbiter_if.sv | 25 ++
 rtl/rf_write_arbiter.sv | 176 +++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Multicycle result handshake into rf_write_arbiter.
// Ports: mc_valid/mc_addr/mc_data from the unit, mc_ready back to it.
interface rf_write_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) ();
   logic              mc_valid;
   logic              mc_ready;
   logic [ADDR_W-1:0] mc_addr;
   logic [DATA_W-1:0] mc_data;

   modport master (
      output mc_valid,
      output mc_addr,
      output mc_data,
      input  mc_ready
   );

   modport slave (
      input  mc_valid,
      input  mc_addr,
      input  mc_data,
      output mc_ready
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write port arbiter: WB vs. buffered multicycle results.
// Ports: clk, rst (sync, active high); wb_we/wb_addr/wb_data writeback;
//   mc (rf_write_arbiter_if.slave) multicycle results with mc_ready;
//   issue_mc/issue_addr set scoreboard bits; chk_addr_a/b -> busy_a/b;
//   stall_req asks decode to freeze so the FIFO can drain;
//   rf_we/rf_waddr/rf_wdata registered RF write; fifo_count occupancy.
// Optional: define RF_WR_BYPASS_EN to let an mc result skip an empty FIFO.
module rf_write_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            wb_we,
   input  logic [ADDR_W-1:0]               wb_addr,
   input  logic [DATA_W-1:0]               wb_data,
   rf_write_arbiter_if.slave               mc,
   input  logic                            issue_mc,
   input  logic [ADDR_W-1:0]               issue_addr,
   input  logic [ADDR_W-1:0]               chk_addr_a,
   input  logic [ADDR_W-1:0]               chk_addr_b,
   output logic                            busy_a,
   output logic                            busy_b,
   output logic                            stall_req,
   output logic                            rf_we,
   output logic [ADDR_W-1:0]               rf_waddr,
   output logic [DATA_W-1:0]               rf_wdata,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int NREG = 1 << ADDR_W;

   localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
   localparam logic [SW-1:0] STARVE_MX = SW'(STARVE_LIMIT);

   // FIFO storage and pointers
   logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
   logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;

   logic [NREG-1:0]   pending;
   logic [NREG-1:0]   pend_nxt;
   logic [SW-1:0]     starve_cnt;
   logic [SW-1:0]     starve_nxt;

   logic              fifo_empty;
   logic              fifo_full;
   logic              wb_gnt;
   logic              pop;
   logic              byp;
   logic              push;
   logic              clr_en;
   logic [ADDR_W-1:0] clr_addr;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CNT_FULL);
   assign head_addr  = addr_mem[rd_ptr];
   assign head_data  = data_mem[rd_ptr];

   assign mc.mc_ready = !fifo_full;
   assign fifo_count  = count;
   assign busy_a      = pending[chk_addr_a];
   assign busy_b      = pending[chk_addr_b];

   // WB always wins; writes to x0 are not real writes.
   assign wb_gnt = wb_we && (wb_addr != '0);
   assign pop    = !wb_gnt && !fifo_empty;

`ifdef RF_WR_BYPASS_EN
   assign byp = !wb_gnt && fifo_empty &&
                mc.mc_valid && (mc.mc_addr != '0);
`else
   assign byp = 1'b0;
`endif

   // x0 results are accepted (handshake completes) but dropped.
   assign push = mc.mc_valid && !fifo_full &&
                 (mc.mc_addr != '0) && !byp;

   assign clr_en   = pop || byp;
   assign clr_addr = pop ? head_addr : mc.mc_addr;

   // Clear first so a same-cycle set of that register wins.
   always_comb begin
      pend_nxt = pending;
      if (clr_en) begin
         pend_nxt[clr_addr] = 1'b0;
      end
      if (issue_mc && (issue_addr != '0)) begin
         pend_nxt[issue_addr] = 1'b1;
      end
      pend_nxt[0] = 1'b0;
   end

   // Counts cycles a queued result loses the port to WB; saturates.
   always_comb begin
      starve_nxt = starve_cnt;
      if (fifo_empty || pop) begin
         starve_nxt = '0;
      end else if (wb_gnt && (starve_cnt != STARVE_MX)) begin
         starve_nxt = starve_cnt + SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr] <= mc.mc_addr;
         data_mem[wr_ptr] <= mc.mc_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending    <= '0;
         starve_cnt <= '0;
         stall_req  <= 1'b0;
      end else begin
         pending    <= pend_nxt;
         starve_cnt <= starve_nxt;
         stall_req  <= (starve_nxt == STARVE_MX);
      end
   end

   // Address/data hold their last value while no write is granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else if (wb_gnt) begin
         rf_we    <= 1'b1;
         rf_waddr <= wb_addr;
         rf_wdata <= wb_data;
      end else if (pop) begin
         rf_we    <= 1'b1;
         rf_waddr <= head_addr;
         rf_wdata <= head_data;
      end else if (byp) begin
         rf_we    <= 1'b1;
         rf_waddr <= mc.mc_addr;
         rf_wdata <= mc.mc_data;
      end else begin
         rf_we    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter.
// Expected RF writes are queued per source and checked as they appear.
module tb_rf_write_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          wb_we;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          issue_mc;
   logic [AW-1:0] issue_addr;
   logic [AW-1:0] chk_addr_a;
   logic [AW-1:0] chk_addr_b;
   logic          busy_a;
   logic          busy_b;
   logic          stall_req;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [1:0]    fifo_count;

   rf_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) mcif ();

   rf_write_arbiter #(
      .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(2), .STARVE_LIMIT(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wb_we      (wb_we),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .mc         (mcif),
      .issue_mc   (issue_mc),
      .issue_addr (issue_addr),
      .chk_addr_a (chk_addr_a),
      .chk_addr_b (chk_addr_b),
      .busy_a     (busy_a),
      .busy_b     (busy_b),
      .stall_req  (stall_req),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   logic [AW+DW-1:0] q_wb[$];
   logic [AW+DW-1:0] q_mc[$];
   logic             wb_fire = 1'b0;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // WB sampled at an edge owns the write that follows it.
   always @(posedge clk) begin
      wb_fire = !rst && wb_we && (wb_addr != '0);
   end

   always @(negedge clk) begin
      if (rf_we) begin
         if (wb_fire) begin
            if (q_wb.size() == 0) chk("wb_unexp", 1, 0);
            else chk("wb_wr", {rf_waddr, rf_wdata}, q_wb.pop_front());
         end else begin
            if (q_mc.size() == 0) chk("mc_unexp", 1, 0);
            else chk("mc_wr", {rf_waddr, rf_wdata}, q_mc.pop_front());
         end
      end else if (wb_fire) begin
         chk("wb_miss", 0, 1);
      end
   end

   task automatic wb(input logic en, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
      wb_we   = en;
      wb_addr = a;
      wb_data = d;
      if (en && a != '0) q_wb.push_back({a, d});
   endtask

   task automatic mc(input logic v, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
      mcif.mc_valid = v;
      mcif.mc_addr  = a;
      mcif.mc_data  = d;
      if (v && a != '0) q_mc.push_back({a, d});
   endtask

   initial begin
      rst = 1'b1;
      wb(0, 0, 0);
      mc(0, 0, 0);
      issue_mc   = 0;
      issue_addr = 0;
      chk_addr_a = 0;
      chk_addr_b = 0;
      step();
      step();
      rst = 1'b0;
      step();
      chk("rst_we", rf_we, 0);
      chk("rst_waddr", rf_waddr, 0);
      chk("rst_rdy", mcif.mc_ready, 1);
      chk("rst_cnt", fifo_count, 0);
      chk("rst_busy", {busy_a, busy_b}, 0);
      chk("rst_stall", stall_req, 0);

      // Plain WB write, then a WB write to x0
      wb(1, 8, 9);
      step();
      wb(0, 0, 0);
      chk("wb_we", rf_we, 1);
      chk("wb_addr", rf_waddr, 8);
      wb(1, 0, 5);
      step();
      wb(0, 0, 0);
      chk("x0_we", rf_we, 0);
      chk("x0_hold", {rf_waddr, rf_wdata}, {5'd8, 32'd9});

      // Scoreboard on a multicycle result
      issue_mc   = 1;
      issue_addr = 11;
      step();
      issue_mc   = 0;
      chk_addr_a = 11;
      #1;
      chk("busy_set", busy_a, 1);
      step();
      chk("busy_hold", busy_a, 1);
      mc(1, 11, 32'h24);
      step();
      mc(0, 0, 0);
`ifdef RF_WR_BYPASS_EN
      chk("byp_we", rf_we, 1);
      chk("byp_wr", {rf_waddr, rf_wdata}, {5'd11, 32'h24});
      chk("byp_cnt", fifo_count, 0);
`else
      chk("mc_n1_we", rf_we, 0);
      chk("mc_n1_busy", busy_a, 1);
      chk("mc_n1_cnt", fifo_count, 1);
      step();
      chk("mc_n2_we", rf_we, 1);
      chk("mc_n2_wr", {rf_waddr, rf_wdata}, {5'd11, 32'h24});
`endif
      chk("busy_clr", busy_a, 0);

      // x0 result is accepted but dropped
      mc(1, 0, 7);
      step();
      mc(0, 0, 0);
      chk("mc0_cnt", fifo_count, 0);
      step();
      chk("mc0_we", rf_we, 0);

      // Starvation under continuous WB
      wb(1, 9, 32'h100);
      mc(1, 13, 32'hA1);
      step();
      wb(1, 9, 32'h101);
      mc(1, 14, 32'hB2);
      step();
      mc(0, 0, 0);
      chk("full_cnt", fifo_count, 2);
      chk("full_rdy", mcif.mc_ready, 0);
      for (int i = 0; i < 2; i++) begin
         wb(1, 9, 32'h102 + i);
         step();
      end
      chk("stall_pre", stall_req, 0);
      wb(1, 9, 32'h104);
      step();
      chk("stall_on", stall_req, 1);
      wb(1, 9, 32'h105);
      step();
      chk("stall_wbpri", stall_req, 1);
      chk("stall_cnt", fifo_count, 2);
      wb(0, 0, 0);
      step();
      chk("drain1_wr", {rf_waddr, rf_wdata}, {5'd13, 32'hA1});
      chk("drain1_stall", stall_req, 0);
      chk("drain1_cnt", fifo_count, 1);
      step();
      chk("drain2_wr", {rf_waddr, rf_wdata}, {5'd14, 32'hB2});
      chk("drain2_cnt", fifo_count, 0);

      // Set and clear of x12 in the same cycle
      issue_mc   = 1;
      issue_addr = 12;
      step();
      issue_mc   = 0;
      wb(1, 9, 32'h200);
      mc(1, 12, 32'h55);
      step();
      wb(0, 0, 0);
      mc(0, 0, 0);
      issue_mc   = 1;
      issue_addr = 12;
      step();
      issue_mc   = 0;
      chk_addr_b = 12;
      #1;
      chk("setwin_wr", {rf_waddr, rf_wdata}, {5'd12, 32'h55});
      chk("setwin_busy", busy_b, 1);

      // Reset while full with pending bits
      wb(1, 9, 32'h300);
      mc(1, 17, 32'h1);
      issue_mc   = 1;
      issue_addr = 15;
      step();
      issue_mc   = 0;
      wb(1, 9, 32'h301);
      mc(1, 18, 32'h2);
      step();
      mc(0, 0, 0);
      wb(0, 0, 0);
      chk_addr_a = 15;
      #1;
      chk("prerst_cnt", fifo_count, 2);
      chk("prerst_busy", busy_a, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      q_mc.delete();
      chk("rst2_cnt", fifo_count, 0);
      chk("rst2_rdy", mcif.mc_ready, 1);
      chk("rst2_busy", {busy_a, busy_b}, 0);
      chk("rst2_we", rf_we, 0);
      chk("rst2_stall", stall_req, 0);
      for (int i = 0; i < 4; i++) step();
      chk("rst2_idle", rf_we, 0);

      chk("q_wb_left", q_wb.size(), 0);
      chk("q_mc_left", q_mc.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
